// File: rtl/f1_light_sequencer.sv
// F1-style start-lights sequencer: lights fill on tick, hold for an LFSR-derived delay, then go out.
// Define F1_REACTION_TIMER_EN to measure driver reaction time after lights-out.
module f1_light_sequencer #(
    parameter int LIGHTS   = 8,
    parameter int RT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                tick,
    input  logic                react,
    input  logic [3:0]          lfsr_in,
    output logic                lfsr_en,
    output logic [LIGHTS-1:0]   data_out,
    output logic                busy,
    output logic                rt_valid,
    output logic                jump_start,
    output logic [RT_WIDTH-1:0] reaction_time
);

    typedef enum logic [2:0] {IDLE, SEQ, HOLD, OUT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [LIGHTS-1:0] data_reg, data_next, data_shift;
    logic [3:0]        delay_reg, delay_next;
    logic              jump_reg, jump_next;

`ifdef F1_REACTION_TIMER_EN
    localparam logic [RT_WIDTH-1:0] RT_MAX = '1;
    logic [RT_WIDTH-1:0] rt_cnt_reg, rt_cnt_next;
    logic [RT_WIDTH-1:0] rt_reg, rt_next;
    logic                rt_valid_reg, rt_valid_next;
`endif

    // Next light pattern: shift up with a new light entering at bit 0.
    assign data_shift[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < LIGHTS; gi++) begin : g_shift
            assign data_shift[gi] = data_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            delay_reg <= '0;
            jump_reg  <= 1'b0;
`ifdef F1_REACTION_TIMER_EN
            rt_cnt_reg   <= '0;
            rt_reg       <= '0;
            rt_valid_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            delay_reg <= delay_next;
            jump_reg  <= jump_next;
`ifdef F1_REACTION_TIMER_EN
            rt_cnt_reg   <= rt_cnt_next;
            rt_reg       <= rt_next;
            rt_valid_reg <= rt_valid_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        delay_next = delay_reg;
        jump_next  = jump_reg;
`ifdef F1_REACTION_TIMER_EN
        rt_cnt_next   = rt_cnt_reg;
        rt_next       = rt_reg;
        rt_valid_next = rt_valid_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                if (state_reg == IDLE) data_next = '0;
                if (trigger) begin
                    state_next = SEQ;
                    data_next  = '0;
                    jump_next  = 1'b0;
`ifdef F1_REACTION_TIMER_EN
                    rt_next       = '0;
                    rt_valid_next = 1'b0;
`endif
                end
            end
            SEQ, HOLD: begin
                // react wins over a coincident tick: any early reaction is a jump start
                if (react) begin
                    state_next = DONE;
                    data_next  = '0;
                    jump_next  = 1'b1;
`ifdef F1_REACTION_TIMER_EN
                    rt_next       = '0;
                    rt_valid_next = 1'b0;
`endif
                end else if (tick) begin
                    if (state_reg == SEQ) begin
                        if (&data_reg) begin
                            state_next = HOLD;
                            delay_next = (lfsr_in == 4'd0) ? 4'd1 : lfsr_in;
                        end else begin
                            data_next = data_shift;
                        end
                    end else if (delay_reg <= 4'd1) begin
                        state_next = OUT;
                        data_next  = '0;
`ifdef F1_REACTION_TIMER_EN
                        rt_cnt_next = '0;
`endif
                    end else begin
                        delay_next = delay_reg - 4'd1;
                    end
                end
            end
            OUT: begin
`ifdef F1_REACTION_TIMER_EN
                if (rt_cnt_reg != RT_MAX) rt_cnt_next = rt_cnt_reg + 1'b1;
                if (react) begin
                    state_next    = DONE;
                    rt_next       = rt_cnt_reg;
                    rt_valid_next = 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_out   = data_reg;
    assign jump_start = jump_reg;
    assign busy       = (state_reg == SEQ) || (state_reg == HOLD) || (state_reg == OUT);
    assign lfsr_en    = (state_reg == IDLE) || (state_reg == SEQ);

`ifdef F1_REACTION_TIMER_EN
    assign reaction_time = rt_reg;
    assign rt_valid      = rt_valid_reg;
`else
    assign reaction_time = '0;
    assign rt_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Randomized directed bench for f1_light_sequencer; a second instance with a 4-bit
// reaction counter shares the stimulus to exercise saturation.
module tb_f1_light_sequencer;

    localparam int LIGHTS = 8;
    localparam int RTW    = 16;
    localparam int RTW_S  = 4;

    logic             clk = 1'b0;
    logic             rst, trigger, tick, react;
    logic [3:0]       lfsr_in;
    logic             lfsr_en, busy, rt_valid, jump_start;
    logic [LIGHTS-1:0] data_out;
    logic [RTW-1:0]   reaction_time;
    logic             s_lfsr_en, s_busy, s_rt_valid, s_jump_start;
    logic [LIGHTS-1:0] s_data_out;
    logic [RTW_S-1:0] s_reaction_time;

    int n_pass   = 0;
    int n_checks = 0;

    f1_light_sequencer #(.LIGHTS(LIGHTS), .RT_WIDTH(RTW)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .react(react),
        .lfsr_in(lfsr_in), .lfsr_en(lfsr_en), .data_out(data_out), .busy(busy),
        .rt_valid(rt_valid), .jump_start(jump_start), .reaction_time(reaction_time)
    );

    f1_light_sequencer #(.LIGHTS(LIGHTS), .RT_WIDTH(RTW_S)) dut_s (
        .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .react(react),
        .lfsr_in(lfsr_in), .lfsr_en(s_lfsr_en), .data_out(s_data_out), .busy(s_busy),
        .rt_valid(s_rt_valid), .jump_start(s_jump_start), .reaction_time(s_reaction_time)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive inputs, let one rising edge sample them, then settle 1 time unit.
    task automatic step(input logic t, input logic r, input logic trg, input logic [3:0] l);
        tick = t; react = r; trigger = trg; lfsr_in = l;
        @(posedge clk);
        #1;
    endtask

    // Expected lights after t ticks of a run whose lights-out tick is number total.
    function automatic logic [LIGHTS-1:0] lights_after(input int t, input int total);
        logic [LIGHTS-1:0] v;
        v = '0;
        if (t < total)
            for (int i = 0; i < LIGHTS && i < t; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int sat(input int v, input int width);
        int mx;
        mx = (1 << width) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rtv"}, 32'(rt_valid), 32'd0);
        chk({tag, "_jump"}, 32'(jump_start), 32'd0);
        chk({tag, "_lfsr_en"}, 32'(lfsr_en), 32'd1);
    endtask

    // One start sequence. jump_tick: tick number carrying react (0 = none);
    // abort_tick: tick after which rst is held 2 cycles (0 = none);
    // delay: OUT cycles before react; gap: idle cycles between ticks.
    task automatic run_seq(input int lf, input int jump_tick, input int abort_tick,
                           input int delay, input int gap);
        int total;
        int exp_rt;
        total = LIGHTS + 1 + ((lf == 0) ? 1 : lf);
        step(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        chk("trig_data", 32'(data_out), 32'd0);
        chk("trig_busy", 32'(busy), 32'd1);
        chk("trig_jump", 32'(jump_start), 32'd0);
        chk("trig_rtv", 32'(rt_valid), 32'd0);
        chk("trig_lfsr_en", 32'(lfsr_en), 32'd1);
        for (int t = 1; t <= total; t++) begin
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                chk("gap_data", 32'(data_out), 32'(lights_after(t - 1, total)));
            end
            step(1'b1, 1'(t == jump_tick), 1'($urandom_range(0, 1)),
                 (t == LIGHTS + 1) ? 4'(lf) : 4'($urandom_range(0, 15)));
            if (t == jump_tick) begin
                chk("jump_data", 32'(data_out), 32'd0);
                chk("jump_flag", 32'(jump_start), 32'd1);
                chk("jump_rtv", 32'(rt_valid), 32'd0);
                chk("jump_rt", 32'(reaction_time), 32'd0);
                chk("jump_busy", 32'(busy), 32'd0);
                repeat (3) begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
                    chk("done_jump", 32'(jump_start), 32'd1);
                    chk("done_data", 32'(data_out), 32'd0);
                    chk("done_lfsr_en", 32'(lfsr_en), 32'd0);
                end
                $display("seq lf=%0d jump at tick %0d", lf, t);
                return;
            end
            chk("tick_data", 32'(data_out), 32'(lights_after(t, total)));
            chk("tick_lfsr_en", 32'(lfsr_en), 32'(t <= LIGHTS));
            chk("tick_busy", 32'(busy), 32'd1);
            if (t == abort_tick) begin
                rst = 1'b1;
                step(1'b0, 1'b0, 1'b0, 4'd0);
                step(1'b0, 1'b0, 1'b0, 4'd0);
                rst = 1'b0;
                chk_idle("abort");
                $display("seq lf=%0d reset after tick %0d", lf, t);
                return;
            end
        end
`ifdef F1_REACTION_TIMER_EN
        for (int c = 0; c < delay; c++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            chk("out_busy", 32'(busy), 32'd1);
            chk("out_rtv", 32'(rt_valid), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        exp_rt = sat(delay, RTW);
        chk("react_rt", 32'(reaction_time), 32'(exp_rt));
        chk("react_rt_sat", 32'(s_reaction_time), 32'(sat(delay, RTW_S)));
        chk("react_rtv", 32'(rt_valid), 32'd1);
        chk("react_jump", 32'(jump_start), 32'd0);
        chk("react_busy", 32'(busy), 32'd0);
        repeat (3) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
            chk("done_rt", 32'(reaction_time), 32'(exp_rt));
            chk("done_rtv", 32'(rt_valid), 32'd1);
            chk("done_lfsr_en", 32'(lfsr_en), 32'd0);
        end
`else
        exp_rt = 0;
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        chk_idle("after_out");
        chk("after_out_rt", 32'(reaction_time), 32'd0);
`endif
        $display("seq lf=%0d delay=%0d reaction_time=%0d", lf, delay, exp_rt);
    endtask

    initial begin
        int lf, total, jt;
        rst = 1'b1; trigger = 1'b0; tick = 1'b0; react = 1'b0; lfsr_in = 4'd0;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_rt", 32'(reaction_time), 32'd0);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            chk_idle("idle");
        end
        run_seq(5, 0, 0, 37, 3);
        run_seq($urandom_range(0, 15), 3, 0, 0, 3);
        run_seq(0, 0, 0, 0, 2);
        run_seq($urandom_range(2, 15), 0, LIGHTS + 2, 0, 1);
        run_seq($urandom_range(0, 15), 0, 0, 40, 1);
        repeat (6) begin
            lf    = $urandom_range(0, 15);
            total = LIGHTS + 1 + ((lf == 0) ? 1 : lf);
            jt    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, total) : 0;
            run_seq(lf, jt, 0, $urandom_range(0, 60), $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
